// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game video/food pipeline.
//   GRID_W/GRID_H   : playfield size in cells (40x30)
//   CELL_SHIFT      : log2 of the 16x16 pixel cell
//   H_ACTIVE/V_ACTIVE : visible pixel area (640x480)
//   spawn_state_e   : food spawner FSM states
//   layer_t         : 2-bit pixel layer code for the colour mixer
package snake_pkg;

    localparam int unsigned GRID_W     = 40;
    localparam int unsigned GRID_H     = 30;
    localparam int unsigned CELL_SHIFT = 4;
    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;

    localparam int unsigned CELL_X_W   = 6;
    localparam int unsigned CELL_Y_W   = 5;
    localparam int unsigned PIX_W      = 11;
    localparam int unsigned LFSR_W     = 16;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ACTIVE = 2'd2
    } spawn_state_e;

    typedef logic [1:0] layer_t;

    localparam layer_t LAYER_NONE = 2'b00;
    localparam layer_t LAYER_FOOD = 2'b11;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1 (maximal length).
// Shifts every cycle; a nonzero seed therefore never reaches the all-zero state.
//   Clock  : system clock
//   Reset  : async active-high, loads SEED
//   oState : current LFSR state
module lfsr16
    import snake_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [LFSR_W-1:0] oState
);

    logic fb_c;

    // Taps 16,14,13,11 map to bit indices 15,13,12,10.
    assign fb_c = oState[15] ^ oState[13] ^ oState[12] ^ oState[10];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oState <= SEED;
        end else begin
            oState <= {oState[LFSR_W-2:0], fb_c};
        end
    end

endmodule

// File: rtl/food_spawner.sv
// Food placement for the snake game: picks random free cells, detects the head
// eating the food, and renders the food cell as a pixel layer.
//   Clock, Reset          : system clock, async active-high reset
//   iCol, iRow            : current pixel from the VGA timing stage
//   iHeadX/Y, iHeadValid  : snake head cell, valid on the advance pulse
//   iProbeOccupied        : body occupancy of the probe cell, one cycle after probe
//   oProbeX/Y             : candidate cell under occupancy check
//   oFoodX/Y, oFoodValid  : committed food cell
//   oEaten                : one-cycle pulse when the head enters the food
//   oFoodIcon             : layer code for the pixel one cycle earlier
module food_spawner
    import snake_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [PIX_W-1:0]    iCol,
    input  logic [PIX_W-1:0]    iRow,
    input  logic [CELL_X_W-1:0] iHeadX,
    input  logic [CELL_Y_W-1:0] iHeadY,
    input  logic                iHeadValid,
    input  logic                iProbeOccupied,
    output logic [CELL_X_W-1:0] oProbeX,
    output logic [CELL_Y_W-1:0] oProbeY,
    output logic [CELL_X_W-1:0] oFoodX,
    output logic [CELL_Y_W-1:0] oFoodY,
    output logic                oFoodValid,
    output logic                oEaten,
    output layer_t              oFoodIcon
);

    logic [LFSR_W-1:0]   lfsr_q;
    spawn_state_e        state_q;
    logic [CELL_X_W-1:0] cand_x_c;
    logic [CELL_Y_W-1:0] cand_y_c;
    logic                cand_ok_c;
    logic                head_hit_c;
    logic                icon_hit_c;
    logic                unused_c;

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .Clock  (Clock),
        .Reset  (Reset),
        .oState (lfsr_q)
    );

    // Candidate cell straight from LFSR bit fields; out-of-grid draws are skipped.
    assign cand_x_c  = lfsr_q[5:0];
    assign cand_y_c  = lfsr_q[12:8];
    assign cand_ok_c = (cand_x_c < CELL_X_W'(GRID_W)) && (cand_y_c < CELL_Y_W'(GRID_H));
    assign unused_c  = ^{lfsr_q[15:13], lfsr_q[7:6]};

    assign head_hit_c = iHeadValid && (iHeadX == oFoodX) && (iHeadY == oFoodY);

    // Cell index is the pixel coordinate shifted right by CELL_SHIFT.
    assign icon_hit_c = oFoodValid
                     && (iCol < PIX_W'(H_ACTIVE))
                     && (iRow < PIX_W'(V_ACTIVE))
                     && (iCol[CELL_SHIFT+CELL_X_W-1:CELL_SHIFT] == oFoodX)
                     && (iRow[CELL_SHIFT+CELL_Y_W-1:CELL_SHIFT] == oFoodY);

    // Spawner FSM with registered outputs; icon uses pre-edge food state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_SEARCH;
            oProbeX    <= '0;
            oProbeY    <= '0;
            oFoodX     <= '0;
            oFoodY     <= '0;
            oFoodValid <= 1'b0;
            oEaten     <= 1'b0;
            oFoodIcon  <= LAYER_NONE;
        end else begin
            oEaten    <= 1'b0;
            oFoodIcon <= icon_hit_c ? LAYER_FOOD : LAYER_NONE;
            case (state_q)
                ST_SEARCH: begin
                    if (cand_ok_c) begin
                        oProbeX <= cand_x_c;
                        oProbeY <= cand_y_c;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!iProbeOccupied) begin
                        oFoodX     <= oProbeX;
                        oFoodY     <= oProbeY;
                        oFoodValid <= 1'b1;
                        state_q    <= ST_ACTIVE;
                    end else begin
                        state_q    <= ST_SEARCH;
                    end
                end
                ST_ACTIVE: begin
                    if (head_hit_c) begin
                        oEaten     <= 1'b1;
                        oFoodValid <= 1'b0;
                        state_q    <= ST_SEARCH;
                    end
                end
                default: state_q <= ST_SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
module tb_food_spawner;

    logic        Clock;
    logic        Reset;
    logic [10:0] iCol;
    logic [10:0] iRow;
    logic [5:0]  iHeadX;
    logic [4:0]  iHeadY;
    logic        iHeadValid;
    logic        iProbeOccupied;
    logic [5:0]  oProbeX;
    logic [4:0]  oProbeY;
    logic [5:0]  oFoodX;
    logic [4:0]  oFoodY;
    logic        oFoodValid;
    logic        oEaten;
    logic [1:0]  oFoodIcon;

    localparam int SEQ_LEN = 131072;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int cur_fx = 0;
    int cur_fy = 0;
    logic [15:0] lseq [0:SEQ_LEN-1];

    food_spawner #(.LFSR_SEED(16'hACE1)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iCol           (iCol),
        .iRow           (iRow),
        .iHeadX         (iHeadX),
        .iHeadY         (iHeadY),
        .iHeadValid     (iHeadValid),
        .iProbeOccupied (iProbeOccupied),
        .oProbeX        (oProbeX),
        .oProbeY        (oProbeY),
        .oFoodX         (oFoodX),
        .oFoodY         (oFoodY),
        .oFoodValid     (oFoodValid),
        .oEaten         (oEaten),
        .oFoodIcon      (oFoodIcon)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference LFSR step from the polynomial x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Edge n after reset release evaluates SEARCH against sequence value n-1.
    function automatic int first_valid(input int from);
        logic [15:0] v;
        for (int m = from; m < SEQ_LEN; m++) begin
            v = lseq[m-1];
            if (int'(v[5:0]) < 40 && int'(v[12:8]) < 30) return m;
        end
        return -1;
    endfunction

    // Predict which probe gets committed: reject the first nrej probes and,
    // when want is set, every probe other than (tx,ty).
    task automatic plan(input int start, input int nrej, input bit want,
                        input int tx, input int ty,
                        output int probe_edge, output int px, output int py);
        int e;
        int k;
        logic [15:0] v;
        e = start;
        k = 0;
        probe_edge = -1;
        px = 0;
        py = 0;
        while (e < SEQ_LEN) begin
            int m;
            m = first_valid(e);
            if (m < 0) return;
            v  = lseq[m-1];
            px = int'(v[5:0]);
            py = int'(v[12:8]);
            if (k < nrej || (want && (px != tx || py != ty))) begin
                k++;
                e = m + 2;
            end else begin
                probe_edge = m;
                return;
            end
        end
    endtask

    function automatic logic [1:0] exp_icon(input int col, input int row, input bit v,
                                            input int fx, input int fy);
        if (v && col < 640 && row < 480 && col / 16 == fx && row / 16 == fy) return 2'b11;
        return 2'b00;
    endfunction

    task automatic step();
        @(posedge Clock);
        edge_n++;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({oProbeX, oProbeY, oFoodX, oFoodY, oFoodValid, oEaten, oFoodIcon} !== 26'd0) begin
            errors++;
            $display("FAIL %s probe=(%0d,%0d) food=(%0d,%0d) valid=%b eaten=%b icon=%b required all zero",
                     tag, oProbeX, oProbeY, oFoodX, oFoodY, oFoodValid, oEaten, oFoodIcon);
        end
    endtask

    task automatic run_to_probe(input int start, input int nrej, input bit want,
                                input int tx, input int ty, output int probe_edge,
                                output int px, output int py);
        bit early;
        plan(start, nrej, want, tx, ty, probe_edge, px, py);
        iProbeOccupied = 1'b1;
        if (probe_edge < 0) begin
            checks++;
            errors++;
            $display("FAIL plan no probe found from edge %0d", start);
            return;
        end
        early = 1'b0;
        while (edge_n < probe_edge) begin
            step();
            if (oFoodValid || oEaten) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL no_early_commit valid/eaten seen before edge %0d", probe_edge);
        end
        checks++;
        if (oProbeX !== 6'(px) || oProbeY !== 5'(py)) begin
            errors++;
            $display("FAIL probe got=(%0d,%0d) exp=(%0d,%0d) edge=%0d",
                     oProbeX, oProbeY, px, py, edge_n);
        end
        iProbeOccupied = 1'b0;
        iHeadValid     = 1'b0;
    endtask

    task automatic run_to_commit(input int start, input int nrej, input bit want,
                                 input int tx, input int ty);
        int pe;
        int px;
        int py;
        run_to_probe(start, nrej, want, tx, ty, pe, px, py);
        if (pe < 0) return;
        step();
        checks++;
        if (oFoodValid !== 1'b1 || oFoodX !== 6'(px) || oFoodY !== 5'(py)) begin
            errors++;
            $display("FAIL commit got valid=%b (%0d,%0d) exp valid=1 (%0d,%0d)",
                     oFoodValid, oFoodX, oFoodY, px, py);
        end
        cur_fx = px;
        cur_fy = py;
        iProbeOccupied = 1'b1;
    endtask

    task automatic do_eat(output int eat_edge);
        iHeadX     = 6'(cur_fx);
        iHeadY     = 5'(cur_fy);
        iHeadValid = 1'b1;
        step();
        eat_edge   = edge_n;
        iHeadValid = 1'b0;
        checks++;
        if (oEaten !== 1'b1 || oFoodValid !== 1'b0) begin
            errors++;
            $display("FAIL eat got eaten=%b valid=%b exp eaten=1 valid=0", oEaten, oFoodValid);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        iCol = '0; iRow = '0; iHeadX = '0; iHeadY = '0;
        iHeadValid = 1'b0; iProbeOccupied = 1'b0;
        repeat (3) step();
        check_all_zero("reset_hold");
        @(negedge Clock);
        Reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_first_food();
        int pe;
        int px;
        int py;
        int seen;
        plan(1, 0, 1'b0, 0, 0, pe, px, py);
        iProbeOccupied = 1'b0;
        seen = -1;
        for (int i = 0; i < 64 && seen < 0; i++) begin
            step();
            if (oFoodValid === 1'b1) seen = edge_n;
        end
        checks++;
        if (seen < 0 || seen != pe + 1) begin
            errors++;
            $display("FAIL first_food_time got=%0d exp=%0d", seen, pe + 1);
        end
        checks++;
        if (oFoodX !== 6'(px) || oFoodY !== 5'(py) || oFoodX >= 6'd40 || oFoodY >= 5'd30) begin
            errors++;
            $display("FAIL first_food_cell got=(%0d,%0d) exp=(%0d,%0d)", oFoodX, oFoodY, px, py);
        end
        cur_fx = px;
        cur_fy = py;
        iProbeOccupied = 1'b1;
    endtask

    task automatic test_place_target();
        int ee;
        do_eat(ee);
        run_to_commit(ee + 1, 0, 1'b1, 5, 7);
    endtask

    task automatic test_icon();
        int c;
        int r;
        int col_tab [6] = '{1104, 720, 639, 80, 95, 2047};
        int row_tab [6] = '{112, 112, 112, 624, 127, 2047};
        for (int pass = 0; pass < 2; pass++) begin
            r = (pass == 0) ? 112 : 128;
            for (int col = 79; col <= 96; col++) begin
                iCol = 11'(col);
                iRow = 11'(r);
                step();
                checks++;
                if (oFoodIcon !== exp_icon(col, r, 1'b1, cur_fx, cur_fy)) begin
                    errors++;
                    $display("FAIL icon_sweep col=%0d row=%0d got=%b exp=%b",
                             col, r, oFoodIcon, exp_icon(col, r, 1'b1, cur_fx, cur_fy));
                end
            end
        end
        for (int i = 0; i < 30; i++) begin
            if (i < 6) begin
                c = col_tab[i];
                r = row_tab[i];
            end else if (($urandom & 1) != 0) begin
                c = 64 + int'($urandom_range(0, 47));
                r = 96 + int'($urandom_range(0, 47));
            end else begin
                c = int'($urandom_range(0, 2047));
                r = int'($urandom_range(0, 2047));
            end
            iCol = 11'(c);
            iRow = 11'(r);
            step();
            checks++;
            if (oFoodIcon !== exp_icon(c, r, 1'b1, cur_fx, cur_fy)) begin
                errors++;
                $display("FAIL icon_rand col=%0d row=%0d got=%b exp=%b",
                         c, r, oFoodIcon, exp_icon(c, r, 1'b1, cur_fx, cur_fy));
            end
        end
    endtask

    task automatic test_head_ignored();
        bit bad;
        int hx;
        int hy;
        bad = 1'b0;
        iHeadX = 6'(cur_fx);
        iHeadY = 5'(cur_fy);
        iHeadValid = 1'b0;
        repeat (5) begin
            step();
            if (oEaten !== 1'b0 || oFoodValid !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL head_no_valid eaten=%b valid=%b exp eaten=0 valid=1", oEaten, oFoodValid);
        end
        bad = 1'b0;
        iHeadValid = 1'b1;
        repeat (12) begin
            hx = int'($urandom_range(0, 39));
            hy = int'($urandom_range(0, 29));
            if (hx == cur_fx && hy == cur_fy) hx = (hx + 1) % 40;
            iHeadX = 6'(hx);
            iHeadY = 5'(hy);
            step();
            if (oEaten !== 1'b0 || oFoodValid !== 1'b1) bad = 1'b1;
        end
        iHeadValid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL head_miss eaten=%b valid=%b exp eaten=0 valid=1", oEaten, oFoodValid);
        end
    endtask

    task automatic test_eat_collision();
        int ee;
        iCol = 11'(cur_fx * 16 + 3);
        iRow = 11'(cur_fy * 16 + 9);
        do_eat(ee);
        checks++;
        if (oFoodIcon !== 2'b11) begin
            errors++;
            $display("FAIL eat_icon_pre got=%b exp=11", oFoodIcon);
        end
        iHeadValid = 1'b1;
        step();
        checks++;
        if (oFoodIcon !== 2'b00 || oEaten !== 1'b0) begin
            errors++;
            $display("FAIL eat_after got icon=%b eaten=%b exp icon=00 eaten=0", oFoodIcon, oEaten);
        end
        run_to_commit(ee + 1, int'($urandom_range(0, 3)), 1'b0, 0, 0);
    endtask

    task automatic test_retry10();
        int ee;
        do_eat(ee);
        run_to_commit(ee + 1, 10, 1'b0, 0, 0);
    endtask

    task automatic test_reset_check();
        int ee;
        int pe;
        int px;
        int py;
        do_eat(ee);
        run_to_probe(ee + 1, int'($urandom_range(0, 2)), 1'b0, 0, 0, pe, px, py);
        Reset = 1'b1;
        #1;
        check_all_zero("reset_in_check");
        Reset  = 1'b0;
        edge_n = 0;
        run_to_commit(1, int'($urandom_range(0, 4)), 1'b0, 0, 0);
    endtask

    task automatic test_reset_active();
        iCol = 11'(cur_fx * 16 + 7);
        iRow = 11'(cur_fy * 16 + 7);
        step();
        checks++;
        if (oFoodIcon !== exp_icon(cur_fx * 16 + 7, cur_fy * 16 + 7, 1'b1, cur_fx, cur_fy)) begin
            errors++;
            $display("FAIL active_icon got=%b exp=11", oFoodIcon);
        end
        Reset = 1'b1;
        #1;
        check_all_zero("reset_in_active");
        Reset  = 1'b0;
        edge_n = 0;
        run_to_commit(1, int'($urandom_range(0, 4)), 1'b0, 0, 0);
    endtask

    initial begin
        lseq[0] = 16'hACE1;
        for (int i = 1; i < SEQ_LEN; i++) lseq[i] = lfsr_next(lseq[i-1]);
        test_reset();
        test_first_food();
        test_place_target();
        test_icon();
        test_head_ignored();
        test_eat_collision();
        test_retry10();
        test_reset_check();
        test_reset_active();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
